// File: rtl/fractal_sync_responder.sv
// fractal_sync_responder
// One node of a binary sync tree. Each child posts a request carrying the
// tree level it wants to synchronise at. When both children are pending at
// the same level, the node either completes the barrier locally (level equals
// NODE_LVL) or forwards it to its parent and waits for the parent's ack.
// Out-of-range levels, double requests and level mismatches are reported
// back to the offending child(ren) as one-cycle error pulses.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | collecting child requests, resolves when both slots valid
// FWD_WAIT | barrier forwarded upward, waiting for par_ack_i
// ACK      | ch_ack_o = 2'b11 is being driven for one cycle
module fractal_sync_responder #(
  parameter int LVL_WIDTH = 3,
  parameter int NODE_LVL  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             ch_req_i,
  input  logic [2*LVL_WIDTH-1:0] ch_lvl_i,
  output logic [1:0]             ch_ack_o,
  output logic [1:0]             ch_err_o,
  output logic                   par_req_o,
  output logic [LVL_WIDTH-1:0]   par_lvl_o,
  input  logic                   par_ack_i,
  output logic [15:0]            sync_cnt_o
);

  localparam logic [LVL_WIDTH-1:0] NODE_LVL_V = LVL_WIDTH'(NODE_LVL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD_WAIT = 2'd1,
    ACK      = 2'd2
  } state_t;

  state_t               state_q;
  logic [1:0]           slot_vld_q;
  logic [LVL_WIDTH-1:0] slot_lvl_q [2];
  logic [15:0]          cnt_q;

  logic [LVL_WIDTH-1:0] req_lvl [2];
  logic [1:0]           req_ok;
  logic [1:0]           req_bad;
  logic                 both_vld;
  logic                 lvl_eq;
  logic                 resolve_local;
  logic                 resolve_fwd;
  logic                 resolve_mismatch;
  logic                 clr_slots;

  // Request qualification and barrier resolution conditions.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_lvl[i] = ch_lvl_i[i*LVL_WIDTH +: LVL_WIDTH];
      req_ok[i]  = ch_req_i[i] && !slot_vld_q[i] && (req_lvl[i] >= NODE_LVL_V);
      req_bad[i] = ch_req_i[i] && (slot_vld_q[i] || (req_lvl[i] < NODE_LVL_V));
    end
    both_vld         = &slot_vld_q;
    lvl_eq           = (slot_lvl_q[0] == slot_lvl_q[1]);
    // Captured levels are never below NODE_LVL, so equal-and-not-local means forward.
    resolve_local    = (state_q == IDLE) && both_vld && lvl_eq && (slot_lvl_q[0] == NODE_LVL_V);
    resolve_fwd      = (state_q == IDLE) && both_vld && lvl_eq && (slot_lvl_q[0] != NODE_LVL_V);
    resolve_mismatch = (state_q == IDLE) && both_vld && !lvl_eq;
    // Slots stay occupied while forwarded so new requests in FWD_WAIT are rejected.
    clr_slots        = resolve_local || resolve_mismatch ||
                       ((state_q == FWD_WAIT) && par_ack_i);
  end

  // Pending slots: capture a legal request into an empty slot, clear on resolution.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_vld_q <= 2'b00;
      for (int i = 0; i < 2; i++) slot_lvl_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_ok[i]) begin
          slot_vld_q[i] <= 1'b1;
          slot_lvl_q[i] <= req_lvl[i];
        end else if (clr_slots) begin
          slot_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // Error pulses: per-child protocol errors plus both bits on a level mismatch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_err_o <= 2'b00;
    end else begin
      ch_err_o <= req_bad | {2{resolve_mismatch}};
    end
  end

  // Barrier FSM with registered ack/forward outputs and completion counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ch_ack_o  <= 2'b00;
      par_req_o <= 1'b0;
      par_lvl_o <= '0;
      cnt_q     <= 16'h0000;
    end else begin
      ch_ack_o  <= 2'b00;
      par_req_o <= 1'b0;
      par_lvl_o <= '0;
      case (state_q)
        IDLE: begin
          if (resolve_local) begin
            state_q  <= ACK;
            ch_ack_o <= 2'b11;
            cnt_q    <= cnt_q + 16'd1;
          end else if (resolve_fwd) begin
            state_q   <= FWD_WAIT;
            par_req_o <= 1'b1;
            par_lvl_o <= slot_lvl_q[0];
          end
        end
        FWD_WAIT: begin
          if (par_ack_i) begin
            state_q  <= ACK;
            ch_ack_o <= 2'b11;
            cnt_q    <= cnt_q + 16'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sync_cnt_o = cnt_q;

endmodule

// File: tb/tb_fractal_sync_responder.sv
// Bench for fractal_sync_responder (LVL_WIDTH=3, NODE_LVL=1).
// Each table row is one clock cycle: the inputs driven in that cycle and the
// outputs expected to be visible during that same cycle.
module tb_fractal_sync_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ch_req = 2'b00;
  logic [5:0]  ch_lvl = 6'd0;
  logic        par_ack = 1'b0;
  logic [1:0]  ch_ack;
  logic [1:0]  ch_err;
  logic        par_req;
  logic [2:0]  par_lvl;
  logic [15:0] sync_cnt;

  fractal_sync_responder #(.LVL_WIDTH(3), .NODE_LVL(1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ch_req_i   (ch_req),
    .ch_lvl_i   (ch_lvl),
    .ch_ack_o   (ch_ack),
    .ch_err_o   (ch_err),
    .par_req_o  (par_req),
    .par_lvl_o  (par_lvl),
    .par_ack_i  (par_ack),
    .sync_cnt_o (sync_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  l0;
    logic [2:0]  l1;
    logic        pack;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic        preq;
    logic [2:0]  plvl;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic        preq;
    logic [2:0]  plvl;
    logic [15:0] cnt;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [1:0] req, logic [2:0] l0, logic [2:0] l1, logic pack,
                              logic [1:0] ack, logic [1:0] err, logic preq, logic [2:0] plvl,
                              logic [15:0] cnt);
    vec_t v;
    v.req = req; v.l0 = l0; v.l1 = l1; v.pack = pack;
    v.ack = ack; v.err = err; v.preq = preq; v.plvl = plvl; v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t idle(logic [15:0] cnt);
    return mk(2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, cnt);
  endfunction

  function automatic vec_t idle_ack(logic [15:0] cnt);
    return mk(2'b00, 3'd0, 3'd0, 1'b0, 2'b11, 2'b00, 1'b0, 3'd0, cnt);
  endfunction

  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_zero(string name);
    check({name, "_ack"},  -1, {14'd0, ch_ack}, 16'd0);
    check({name, "_err"},  -1, {14'd0, ch_err}, 16'd0);
    check({name, "_preq"}, -1, {15'd0, par_req}, 16'd0);
    check({name, "_plvl"}, -1, {13'd0, par_lvl}, 16'd0);
    check({name, "_cnt"},  -1, sync_cnt, 16'd0);
  endtask

  task automatic step(vec_t v, int idx);
    exp_t e;
    @(posedge clk);
    #1;
    ch_req  = v.req;
    ch_lvl  = {v.l1, v.l0};
    par_ack = v.pack;
    e.ack = v.ack; e.err = v.err; e.preq = v.preq; e.plvl = v.plvl; e.cnt = v.cnt; e.idx = idx;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard row %0d: queue empty", idx);
    end else begin
      e = sb.pop_front();
      check("ch_ack",   e.idx, {14'd0, ch_ack},  {14'd0, e.ack});
      check("ch_err",   e.idx, {14'd0, ch_err},  {14'd0, e.err});
      check("par_req",  e.idx, {15'd0, par_req}, {15'd0, e.preq});
      check("par_lvl",  e.idx, {13'd0, par_lvl}, {13'd0, e.plvl});
      check("sync_cnt", e.idx, sync_cnt,         e.cnt);
    end
  endtask

  initial begin
    // Local barrier: left lvl1 at c0, right lvl1 at c3, ack at c5.
    tbl.push_back(mk(2'b01, 3'd1, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd0));
    tbl.push_back(idle(16'd0));
    tbl.push_back(idle(16'd0));
    tbl.push_back(mk(2'b10, 3'd0, 3'd1, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd0));
    tbl.push_back(idle(16'd0));
    tbl.push_back(idle_ack(16'd1));
    tbl.push_back(idle(16'd1));
    // Forwarded barrier: both lvl2 at c0, par_req at c2, par_ack at c10, ack at c11.
    tbl.push_back(mk(2'b11, 3'd2, 3'd2, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd1));
    tbl.push_back(idle(16'd1));
    tbl.push_back(mk(2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 2'b00, 1'b1, 3'd2, 16'd1));
    for (int i = 3; i < 10; i++) tbl.push_back(idle(16'd1));
    tbl.push_back(mk(2'b00, 3'd0, 3'd0, 1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 16'd1));
    tbl.push_back(idle_ack(16'd2));
    // Stray par_ack outside FWD_WAIT is ignored.
    tbl.push_back(mk(2'b00, 3'd0, 3'd0, 1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 16'd2));
    tbl.push_back(idle(16'd2));
    tbl.push_back(idle(16'd2));
    // Level 0 error, then a level mismatch.
    tbl.push_back(mk(2'b01, 3'd0, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd2));
    tbl.push_back(mk(2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 2'b01, 1'b0, 3'd0, 16'd2));
    tbl.push_back(mk(2'b01, 3'd1, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd2));
    tbl.push_back(mk(2'b10, 3'd0, 3'd2, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd2));
    tbl.push_back(idle(16'd2));
    tbl.push_back(mk(2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 2'b11, 1'b0, 3'd0, 16'd2));
    // Slots were cleared: simultaneous requests complete.
    tbl.push_back(mk(2'b11, 3'd1, 3'd1, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd2));
    tbl.push_back(idle(16'd2));
    tbl.push_back(idle_ack(16'd3));
    // One illegal and one legal request in the same cycle.
    tbl.push_back(mk(2'b11, 3'd0, 3'd1, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd3));
    tbl.push_back(mk(2'b01, 3'd1, 3'd0, 1'b0, 2'b00, 2'b01, 1'b0, 3'd0, 16'd3));
    tbl.push_back(idle(16'd3));
    tbl.push_back(idle_ack(16'd4));
    tbl.push_back(idle(16'd4));
    // Double request on the left; old level 1 must survive the dropped level 3.
    tbl.push_back(mk(2'b01, 3'd1, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd4));
    tbl.push_back(idle(16'd4));
    tbl.push_back(mk(2'b01, 3'd3, 3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd4));
    tbl.push_back(mk(2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 2'b01, 1'b0, 3'd0, 16'd4));
    tbl.push_back(mk(2'b10, 3'd0, 3'd1, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd4));
    tbl.push_back(idle(16'd4));
    tbl.push_back(idle_ack(16'd5));
    tbl.push_back(idle(16'd5));
    // Back-to-back barriers: new requests arrive while ch_ack_o is high.
    tbl.push_back(mk(2'b11, 3'd1, 3'd1, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd5));
    tbl.push_back(idle(16'd5));
    tbl.push_back(mk(2'b11, 3'd1, 3'd1, 1'b0, 2'b11, 2'b00, 1'b0, 3'd0, 16'd6));
    tbl.push_back(idle(16'd6));
    tbl.push_back(idle_ack(16'd7));
    tbl.push_back(idle(16'd7));

    // Reset state, asserted asynchronously before any edge is released.
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i], i);

    // Reset while in FWD_WAIT discards the barrier; a late par_ack is ignored.
    step(mk(2'b11, 3'd3, 3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd7), 1000);
    step(idle(16'd7), 1001);
    step(mk(2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 2'b00, 1'b1, 3'd3, 16'd7), 1002);
    step(idle(16'd7), 1003);
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    step(idle(16'd0), 1004);
    rst = 1'b0;
    step(mk(2'b00, 3'd0, 3'd0, 1'b1, 2'b00, 2'b00, 1'b0, 3'd0, 16'd0), 1005);
    step(idle(16'd0), 1006);
    step(idle(16'd0), 1007);
    step(mk(2'b11, 3'd1, 3'd1, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'd0), 1008);
    step(idle(16'd0), 1009);
    step(idle_ack(16'd1), 1010);
    step(idle(16'd1), 1011);

    // Counter wrap from 16'hFFFF.
    force dut.cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    step(idle(16'hFFFF), 2000);
    step(mk(2'b11, 3'd1, 3'd1, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 16'hFFFF), 2001);
    step(idle(16'hFFFF), 2002);
    step(idle_ack(16'h0000), 2003);
    step(idle(16'h0000), 2004);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fractal_sync_responder.md
FRACTAL_SYNC_RESPONDER -- requirements
Module: fractal_sync_responder

Interface
REQ-001 SHALL have parameter LVL_WIDTH, default 3, which is the width of a sync level field.
REQ-002 SHALL have parameter NODE_LVL, default 1, which is the tree level this node resolves; legal range is 1..2^LVL_WIDTH-1.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state samples on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port ch_req_i, input, 2 bits: per-child sync request, a single-cycle pulse; [0] is the left child, [1] the right child.
REQ-006 SHALL have port ch_lvl_i, input, 2 x LVL_WIDTH bits: per-child requested level, qualified by ch_req_i.
REQ-007 SHALL have port ch_ack_o, output, 2 bits: per-child sync-complete pulse.
REQ-008 SHALL have port ch_err_o, output, 2 bits: per-child protocol-error pulse.
REQ-009 SHALL have port par_req_o, output, 1 bit: upward request pulse to the parent node.
REQ-010 SHALL have port par_lvl_o, output, LVL_WIDTH bits: level forwarded upward, valid with par_req_o and 0 otherwise.
REQ-011 SHALL have port par_ack_i, input, 1 bit: single-cycle completion pulse from the parent.
REQ-012 SHALL have port sync_cnt_o, output, 16 bits: number of barriers completed at or through this node.

Function
REQ-013 SHALL keep one pending slot per child, holding a valid bit and a level.
REQ-014 SHALL capture a child request into its slot on the edge ending the cycle where ch_req_i is high.
- Capture happens only if the slot is empty and NODE_LVL <= lvl.
REQ-015 SHALL, on a request with lvl < NODE_LVL (including lvl = 0):
- not capture it;
- pulse that child's ch_err_o in the next cycle.
REQ-016 SHALL, on a request while that child's slot is already valid:
- drop the new request;
- keep the old slot unchanged;
- pulse that child's ch_err_o in the next cycle.
REQ-017 SHALL implement an FSM with states IDLE, FWD_WAIT and ACK; the reset state is IDLE.
REQ-018 SHALL, in IDLE with both slots valid and equal levels equal to NODE_LVL:
- go to ACK;
- clear both slots;
- increment sync_cnt_o.
REQ-019 SHALL, in IDLE with both slots valid and equal levels greater than NODE_LVL:
- drive par_req_o = 1 and par_lvl_o = slot level for exactly one cycle, in the next cycle;
- go to FWD_WAIT.
REQ-020 SHALL, in IDLE with both slots valid but different levels:
- pulse both bits of ch_err_o in the next cycle;
- clear both slots;
- stay in IDLE.
REQ-021 SHALL, in FWD_WAIT, wait without limit for par_ack_i.
- On par_ack_i: clear both slots, increment sync_cnt_o, go to ACK.
REQ-022 SHALL, in ACK, drive ch_ack_o = 2'b11 for exactly one cycle, then return to IDLE.
REQ-023 SHALL give these latencies:
- later child request in cycle t gives ch_ack_o (local case) or par_req_o (forward case) in cycle t+2;
- par_ack_i in cycle u gives ch_ack_o in cycle u+1.
REQ-024 SHALL ignore par_ack_i received outside FWD_WAIT, with no state change and no error.
REQ-025 SHALL, when a child request arrives in the same cycle ch_ack_o is high, capture it normally, because its slot is already cleared.
REQ-026 SHALL, when both children request in the same cycle, capture both.
REQ-027 SHALL, when one request is legal and the other is in error in the same cycle, handle each independently.
REQ-028 SHALL wrap sync_cnt_o from 16'hFFFF to 16'h0000.
REQ-029 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-030 SHALL, while rst_i is high, immediately force the following, regardless of the clock:
- FSM to IDLE and both slots invalid;
- ch_ack_o = 0, ch_err_o = 0, par_req_o = 0, par_lvl_o = 0, sync_cnt_o = 0.
REQ-031 SHALL, on reset during FWD_WAIT or ACK, discard the outstanding barrier, with no ack after reset release.
- A late par_ack_i after reset is ignored per REQ-024.

Verification
REQ-032 SHALL cover a local barrier: NODE_LVL=1; left req lvl 1 in cycle 0, right req lvl 1 in cycle 3 -> ch_ack_o = 11 in cycle 5 only, sync_cnt_o = 1, par_req_o never high.
REQ-033 SHALL cover a forwarded barrier: both children req lvl 2 in cycle 0 -> par_req_o = 1 with par_lvl_o = 2 in cycle 2 only; par_ack_i in cycle 10 -> ch_ack_o = 11 in cycle 11, sync_cnt_o = 1.
REQ-034 SHALL cover errors:
- left req lvl 0 -> ch_err_o = 01 in the next cycle, no capture;
- mismatch left lvl 1 / right lvl 2 -> ch_err_o = 11 two cycles after the later request, both slots cleared.
REQ-035 SHALL cover a double request: left req lvl 1 twice with no right request -> ch_err_o[0] pulses after the second request; a later right lvl 1 request still completes the barrier.
REQ-036 SHALL cover reset mid-forward: assert rst_i in FWD_WAIT, release, then pulse par_ack_i -> no ch_ack_o, all outputs 0, sync_cnt_o = 0.
REQ-037 SHALL cover counter wrap: preload 65535 barriers (or force the counter) -> the next barrier gives sync_cnt_o = 0.
